// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter: master 0 (load/store path) has priority, bounded
// by a starvation counter that forces a master 1 grant after MAX_CONSEC wins.
module dbus_arbiter #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] UART_BASE  = 32'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0] UART_MASK  = 32'hF000_0000,
  parameter int unsigned           MAX_CONSEC = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_wdata,
  output logic                  s_we,
  output logic                  s_re,
  output logic                  s_dmem_sel,
  output logic                  s_uart_sel,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  output logic                  core_stall
);

  localparam int unsigned   CW        = (MAX_CONSEC > 0) ? $clog2(MAX_CONSEC + 1) : 1;
  localparam logic [CW-1:0] STARV_MAX = CW'(MAX_CONSEC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         starv_cnt_q, starv_cnt_d;
  logic                  m0_rvalid_q, m0_rvalid_d;
  logic                  m1_rvalid_q, m1_rvalid_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
  logic                  busy;

  always_comb begin
    state_d     = state_q;
    starv_cnt_d = starv_cnt_q;
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          if (starv_cnt_q == STARV_MAX) begin
            state_d     = GNT1;
            starv_cnt_d = '0;
          end else begin
            // Only reached below STARV_MAX, so the increment saturates by construction.
            state_d     = GNT0;
            starv_cnt_d = starv_cnt_q + 1'b1;
          end
        end else if (m0_req) begin
          state_d     = GNT0;
          starv_cnt_d = '0;
        end else if (m1_req) begin
          state_d     = GNT1;
          starv_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_we    = 1'b0;
    s_re    = 1'b0;
    case (state_q)
      GNT0: begin
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_we    = m0_req & m0_we;
        s_re    = m0_req & ~m0_we;
      end
      GNT1: begin
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_we    = m1_req & m1_we;
        s_re    = m1_req & ~m1_we;
      end
      default: ;
    endcase
    busy       = (state_q == GNT0) || (state_q == GNT1);
    s_uart_sel = busy && ((s_addr & UART_MASK) == UART_BASE);
    s_dmem_sel = busy && !s_uart_sel;
  end

  always_comb begin
    m0_rvalid_d = (state_q == GNT0) && s_re;
    m1_rvalid_d = (state_q == GNT1) && s_re;
    m0_rdata_d  = m0_rvalid_d ? s_rdata : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? s_rdata : m1_rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      starv_cnt_q <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      starv_cnt_q <= starv_cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign m0_gnt     = (state_q == GNT0);
  assign m1_gnt     = (state_q == GNT1);
  assign m0_rvalid  = m0_rvalid_q;
  assign m1_rvalid  = m1_rvalid_q;
  assign m0_rdata   = m0_rdata_q;
  assign m1_rdata   = m1_rdata_q;
  assign core_stall = m0_req & ~m0_gnt;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: a bus-ownership model checked every cycle,
// plus literal expectations from the test plan.
module tb_dbus_arbiter;

  localparam int          MAXC  = 3;
  localparam logic [31:0] UBASE = 32'h8000_0000;
  localparam logic [31:0] UMASK = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [31:0] s_rdata = '0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic        s_we, s_re, s_dmem_sel, s_uart_sel, core_stall;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  always #5 clk = ~clk;

  dbus_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .UART_BASE (UBASE),
    .UART_MASK (UMASK),
    .MAX_CONSEC(MAXC)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_re(s_re),
    .s_dmem_sel(s_dmem_sel), .s_uart_sel(s_uart_sel), .s_rdata(s_rdata),
    .core_stall(core_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: owner of the bus this cycle (-1 none), length of the m0 winning
  // streak against a waiting m1, and the read-return registers.
  int          owner = -1;
  int          streak = 0;
  logic [31:0] x_rd0 = '0, x_rd1 = '0;
  bit          x_rv0 = 1'b0, x_rv1 = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner = -1; streak = 0; x_rd0 = '0; x_rd1 = '0; x_rv0 = 1'b0; x_rv1 = 1'b0;
    end else begin
      x_rv0 = (owner == 0) && m0_req && !m0_we;
      x_rv1 = (owner == 1) && m1_req && !m1_we;
      if (x_rv0) x_rd0 = s_rdata;
      if (x_rv1) x_rd1 = s_rdata;
      if (owner != -1) owner = -1;
      else if (m0_req && m1_req) begin
        if (streak >= MAXC) begin owner = 1; streak = 0; end
        else begin owner = 0; streak = streak + 1; end
      end
      else if (m0_req) begin owner = 0; streak = 0; end
      else if (m1_req) begin owner = 1; streak = 0; end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      logic [31:0] ea, ew;
      logic        ewe, ere, eu;
      ea = '0; ew = '0; ewe = 1'b0; ere = 1'b0;
      if (owner == 0) begin ea = m0_addr; ew = m0_wdata; ewe = m0_req & m0_we; ere = m0_req & ~m0_we; end
      if (owner == 1) begin ea = m1_addr; ew = m1_wdata; ewe = m1_req & m1_we; ere = m1_req & ~m1_we; end
      eu = (owner != -1) && ((ea & UMASK) == UBASE);
      chk1("cmp_m0_gnt", m0_gnt, owner == 0);
      chk1("cmp_m1_gnt", m1_gnt, owner == 1);
      chk("cmp_s_addr", s_addr, ea);
      chk("cmp_s_wdata", s_wdata, ew);
      chk1("cmp_s_we", s_we, ewe);
      chk1("cmp_s_re", s_re, ere);
      chk1("cmp_uart_sel", s_uart_sel, eu);
      chk1("cmp_dmem_sel", s_dmem_sel, (owner != -1) && !eu);
      chk1("cmp_stall", core_stall, m0_req && owner != 0);
      chk1("cmp_m0_rvalid", m0_rvalid, x_rv0);
      chk1("cmp_m1_rvalid", m1_rvalid, x_rv1);
      chk("cmp_m0_rdata", m0_rdata, x_rd0);
      chk("cmp_m1_rdata", m1_rdata, x_rd1);
    end
  end

  int order[$];
  int exp4[8] = '{0, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    // reset state
    #2; m0_req = 1'b1; #1;
    chk1("rst_stall", core_stall, 1'b1);
    chk1("rst_m0_gnt", m0_gnt, 1'b0);
    chk1("rst_s_re", s_re, 1'b0);
    chk1("rst_dmem_sel", s_dmem_sel, 1'b0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    m0_req = 1'b0;
    tick(); tick();
    reset = 1'b1; run_cmp = 1'b1;
    tick();

    // 1: m0 read
    m0_we = 1'b0; m0_addr = 32'h0000_0010; s_rdata = 32'hDEAD_BEEF; m0_req = 1'b1; #1;
    chk1("t1_stall_t", core_stall, 1'b1);
    chk1("t1_gnt_t", m0_gnt, 1'b0);
    tick();
    chk1("t1_gnt", m0_gnt, 1'b1);
    chk1("t1_s_re", s_re, 1'b1);
    chk1("t1_dmem_sel", s_dmem_sel, 1'b1);
    chk1("t1_stall_t1", core_stall, 1'b0);
    tick();
    m0_req = 1'b0; #1;
    chk1("t1_rvalid", m0_rvalid, 1'b1);
    chk("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk1("t1_stall_t2", core_stall, 1'b0);
    tick();
    chk1("t1_rvalid_pulse", m0_rvalid, 1'b0);

    // 1b: new request in the rvalid cycle is arbitrated normally
    m0_addr = 32'h0000_0014; s_rdata = 32'h0BAD_F00D; m0_req = 1'b1;
    tick(); tick();
    m0_req = 1'b0; m1_we = 1'b1; m1_addr = 32'h0000_0100; m1_wdata = 32'h55; m1_req = 1'b1; #1;
    chk1("t1b_rvalid", m0_rvalid, 1'b1);
    chk("t1b_rdata", m0_rdata, 32'h0BAD_F00D);
    tick();
    chk1("t1b_m1_gnt", m1_gnt, 1'b1);
    chk1("t1b_dmem_sel", s_dmem_sel, 1'b1);
    tick();
    m1_req = 1'b0;
    tick();

    // 2: m1 write to UART
    m1_we = 1'b1; m1_addr = 32'h8000_0004; m1_wdata = 32'h0000_00A5; m1_req = 1'b1;
    tick();
    chk1("t2_gnt", m1_gnt, 1'b1);
    chk1("t2_s_we", s_we, 1'b1);
    chk1("t2_uart_sel", s_uart_sel, 1'b1);
    chk1("t2_dmem_sel", s_dmem_sel, 1'b0);
    chk("t2_s_wdata", s_wdata, 32'h0000_00A5);
    // m0 arriving during GNT1 stalls for two cycles
    m0_addr = 32'h0000_0030; s_rdata = 32'h1111_2222; m0_req = 1'b1; #1;
    chk1("t7_stall_a", core_stall, 1'b1);
    tick();
    m1_req = 1'b0; #1;
    chk1("t2_no_rvalid", m1_rvalid, 1'b0);
    chk1("t7_stall_b", core_stall, 1'b1);
    tick();
    chk1("t7_gnt", m0_gnt, 1'b1);
    tick();
    m0_req = 1'b0;
    tick();

    // 3: both requesting
    m0_addr = 32'h0000_0040; m1_we = 1'b0; m1_addr = 32'h0000_0044; s_rdata = 32'h3333_4444;
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    chk1("t3_gnt0", m0_gnt, 1'b1);
    chk1("t3_no_gnt1", m1_gnt, 1'b0);
    tick();
    m0_req = 1'b0; #1;
    chk1("t3_idle_gnt0", m0_gnt, 1'b0);
    chk1("t3_idle_gnt1", m1_gnt, 1'b0);
    tick();
    chk1("t3_gnt1", m1_gnt, 1'b1);
    tick();
    m1_req = 1'b0;
    tick();

    // 4: sustained contention with MAX_CONSEC = 3
    m1_we = 1'b1; m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 15) begin m0_req = 1'b0; m1_req = 1'b0; end
      chk1("t4_alternate", m0_gnt | m1_gnt, (i % 2) == 0);
      if (m0_gnt) order.push_back(0);
      if (m1_gnt) order.push_back(1);
    end
    chk("t4_count", 32'(order.size()), 32'd8);
    for (int k = 0; k < 8; k++)
      chk("t4_order", (k < order.size()) ? 32'(order[k]) : 32'hFFFF_FFFF, 32'(exp4[k]));
    tick();

    // 5: reset during GNT0 of a read
    m0_we = 1'b0; m0_addr = 32'h0000_0020; s_rdata = 32'h1234_5678; m0_req = 1'b1;
    tick();
    chk1("t5_gnt", m0_gnt, 1'b1);
    reset = 1'b0; #1;
    chk1("t5_gnt_abort", m0_gnt, 1'b0);
    chk1("t5_s_re_abort", s_re, 1'b0);
    chk1("t5_rvalid_abort", m0_rvalid, 1'b0);
    chk1("t5_stall_rst", core_stall, 1'b1);
    chk("t5_rdata_rst", m0_rdata, 32'h0);
    tick(); tick();
    reset = 1'b1; #1;
    chk1("t5_no_rvalid", m0_rvalid, 1'b0);
    chk1("t5_no_gnt_yet", m0_gnt, 1'b0);
    tick();
    chk1("t5_regrant", m0_gnt, 1'b1);
    tick();
    m0_req = 1'b0; #1;
    chk1("t5_rvalid", m0_rvalid, 1'b1);
    chk("t5_rdata", m0_rdata, 32'h1234_5678);
    tick();

    // 6: m1 drops req after being sampled
    m1_we = 1'b0; m1_addr = 32'h0000_0080; s_rdata = 32'h9999_AAAA; m1_req = 1'b1;
    tick();
    m1_req = 1'b0; #1;
    chk1("t6_gnt", m1_gnt, 1'b1);
    chk1("t6_s_we", s_we, 1'b0);
    chk1("t6_s_re", s_re, 1'b0);
    tick();
    chk1("t6_no_rvalid", m1_rvalid, 1'b0);
    chk("t6_rdata_hold", m1_rdata, 32'h0);
    tick(); tick();

    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
